// File: rtl/eig_sequencer.sv
// eig_sequencer: central controller of the eigenvalue pipeline.
// Accepts a parameter set, starts the eigen core, waits for its result,
// then starts the output loader. A per-phase watchdog turns a stalled
// core or output loader into a sticky fault.
//
// Optional build macro EIG_SEQ_RETRY_EN: the first watchdog expiry of a
// run while waiting on the core re-issues core_start instead of faulting.
// Without it, every expiry goes straight to FAULT.
module eig_sequencer #(
   parameter logic [15:0] TIMEOUT = 16'd4000,
   parameter int unsigned CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic             prm_valid,
   output logic             prm_ready,
   output logic             core_start,
   input  logic             core_busy,
   input  logic             core_done,
   output logic             ol_start,
   input  logic             ol_busy,
   output logic             timeout,
   output logic             overrun,
   output logic [2:0]       seq_state,
   output logic [CNT_W-1:0] run_count
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      WAIT_CORE = 3'd2,
      EMIT      = 3'd3,
      WAIT_OL   = 3'd4,
      FAULT     = 3'd5
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [15:0]      wd_q;
   logic [15:0]      wd_d;
   logic             wd_expired;
   logic [CNT_W-1:0] run_d;
   logic             timeout_d;
   logic             overrun_d;
   logic             prm_ready_d;
   logic             core_start_d;
   logic             ol_start_d;

`ifdef EIG_SEQ_RETRY_EN
   // Set once the core has been restarted in the current run.
   logic             retry_q;
   logic             retry_d;
`endif

   // The state register is itself the debug view of the sequencer.
   assign seq_state = state_q;

   // Next-state, watchdog and registered-output decode.
   always_comb begin
      state_d      = state_q;
      wd_d         = wd_q;
      run_d        = run_count;
      timeout_d    = timeout;
      overrun_d    = overrun;
      core_start_d = 1'b0;
      ol_start_d   = 1'b0;
`ifdef EIG_SEQ_RETRY_EN
      retry_d      = retry_q;
`endif
      // Expiry is evaluated on the last allowed cycle of a wait phase, so an
      // exit condition seen on that same cycle still wins.
      wd_expired   = (wd_q == (TIMEOUT - 16'd1));

      if (ena) begin
         // A request outside IDLE is dropped but remembered.
         if (prm_valid && (state_q != IDLE)) begin
            overrun_d = 1'b1;
         end

         case (state_q)
            IDLE: begin
               if (prm_valid) begin
                  state_d   = START;
                  timeout_d = 1'b0;
                  overrun_d = 1'b0;
               end
            end

            START: begin
               state_d = WAIT_CORE;
            end

            WAIT_CORE: begin
               if (core_done) begin
                  state_d = EMIT;
               end else if (wd_expired) begin
`ifdef EIG_SEQ_RETRY_EN
                  if (!retry_q) begin
                     state_d = START;
                     retry_d = 1'b1;
                  end else begin
                     state_d = FAULT;
                  end
`else
                  state_d = FAULT;
`endif
               end
            end

            EMIT: begin
               if (!ol_busy) begin
                  state_d    = WAIT_OL;
                  ol_start_d = 1'b1;
               end else if (wd_expired) begin
                  state_d = FAULT;
               end
            end

            WAIT_OL: begin
               // The first WAIT_OL cycle (watchdog still 0) is a guard: the
               // loader has not had time to raise ol_busy after ol_start.
               if ((wd_q != 16'd0) && !ol_busy) begin
                  state_d = IDLE;
                  run_d   = run_count + CNT_W'(1);
               end else if (wd_expired) begin
                  state_d = FAULT;
               end
            end

            FAULT: begin
               // Only leave once both downstream blocks have gone quiet.
               if (!core_busy && !ol_busy) begin
                  state_d = IDLE;
               end
            end

            default: begin
               state_d = IDLE;
            end
         endcase

         // Watchdog restarts on every phase change and only runs while waiting.
         if (state_d != state_q) begin
            wd_d = 16'd0;
         end else if (state_q inside {WAIT_CORE, EMIT, WAIT_OL}) begin
            wd_d = wd_q + 16'd1;
         end

         if (state_d == START) begin
            core_start_d = 1'b1;
         end

         if (state_d == FAULT) begin
            timeout_d = 1'b1;
         end

`ifdef EIG_SEQ_RETRY_EN
         if (state_d == IDLE) begin
            retry_d = 1'b0;
         end
`endif
      end

      prm_ready_d = (state_d == IDLE);
   end

   // State and watchdog registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         wd_q    <= 16'd0;
      end else begin
         state_q <= state_d;
         wd_q    <= wd_d;
      end
   end

   // Registered outputs: strobes, sticky flags and the run counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prm_ready  <= 1'b1;
         core_start <= 1'b0;
         ol_start   <= 1'b0;
         timeout    <= 1'b0;
         overrun    <= 1'b0;
         run_count  <= '0;
      end else begin
         prm_ready  <= prm_ready_d;
         core_start <= core_start_d;
         ol_start   <= ol_start_d;
         timeout    <= timeout_d;
         overrun    <= overrun_d;
         run_count  <= run_d;
      end
   end

`ifdef EIG_SEQ_RETRY_EN
   // Per-run retry marker.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         retry_q <= 1'b0;
      end else begin
         retry_q <= retry_d;
      end
   end
`endif

endmodule

// File: tb/tb_eig_sequencer.sv
// Directed bench for eig_sequencer with a scoreboard of expected core_start
// cycles and expected run_count values at the end of each completed run.
module tb_eig_sequencer;

   localparam logic [15:0] TO = 16'd16;
   localparam int unsigned CW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          ena = 1'b0;
   logic          prm_valid = 1'b0;
   logic          core_busy = 1'b0;
   logic          core_done = 1'b0;
   logic          ol_busy = 1'b0;
   logic          prm_ready;
   logic          core_start;
   logic          ol_start;
   logic          timeout;
   logic          overrun;
   logic [2:0]    seq_state;
   logic [CW-1:0] run_count;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int cs_count = 0;
   int cs_last = -1;
   int ol_count = 0;
   int cs_seen = 0;
   int c0 = 0;
   int ol_before = 0;
   logic [7:0] runs = 8'd0;
   int exp_cs_q[$];
   int exp_run_q[$];

   eig_sequencer #(.TIMEOUT(TO), .CNT_W(CW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena),
      .prm_valid  (prm_valid),
      .prm_ready  (prm_ready),
      .core_start (core_start),
      .core_busy  (core_busy),
      .core_done  (core_done),
      .ol_start   (ol_start),
      .ol_busy    (ol_busy),
      .timeout    (timeout),
      .overrun    (overrun),
      .seq_state  (seq_state),
      .run_count  (run_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Strobe monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (core_start === 1'b1) begin
         cs_count <= cs_count + 1;
         cs_last  <= cyc;
      end
      if (ol_start === 1'b1) begin
         ol_count <= ol_count + 1;
      end
   end

   initial begin
      #200000;
      $display("FAIL tb_time_limit: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic wait_cs(input string tag, input int budget);
      int n;
      int e;
      n = 0;
      while ((cs_count == cs_seen) && (n < budget)) begin
         tick(1);
         n++;
      end
      chk({tag, " core_start seen"}, 32'(cs_count > cs_seen), 32'd1);
      if (exp_cs_q.size() > 0) begin
         e = exp_cs_q.pop_front();
         chk({tag, " core_start cycle"}, cs_last, e);
      end
      cs_seen = cs_count;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int n;
      int e;
      n = 0;
      while ((seq_state !== 3'd0) && (n < budget)) begin
         tick(1);
         n++;
      end
      chk({tag, " back to IDLE"}, seq_state, 32'd0);
      if (exp_run_q.size() > 0) begin
         e = exp_run_q.pop_front();
         chk({tag, " run_count"}, run_count, e);
      end
   endtask

   task automatic start_run(input bit completes);
      prm_valid = 1'b1;
      exp_cs_q.push_back(cyc + 1);
      if (completes) begin
         runs = runs + 8'd1;
         exp_run_q.push_back(int'(runs));
      end
      tick(1);
      prm_valid = 1'b0;
   endtask

   task automatic quick_run(input string tag);
      start_run(1'b1);
      wait_cs(tag, 4);
      core_done = 1'b1;
      tick(1);
      core_done = 1'b0;
      wait_idle(tag, 40);
   endtask

   task automatic wait_fault(input int budget);
      int n;
      n = 0;
      while ((seq_state !== 3'd5) && (n < budget)) begin
         tick(1);
         n++;
      end
   endtask

   initial begin
      // Reset state
      #2 rst_n = 1'b0;
      tick(3);
      chk("rst seq_state", seq_state, 32'd0);
      chk("rst prm_ready", prm_ready, 32'd1);
      chk("rst core_start", core_start, 32'd0);
      chk("rst ol_start", ol_start, 32'd0);
      chk("rst timeout", timeout, 32'd0);
      chk("rst overrun", overrun, 32'd0);
      chk("rst run_count", run_count, 32'd0);
      rst_n = 1'b1;
      ena   = 1'b1;

      // Nominal run: prm_valid in cycle 10
      while (cyc < 10) tick(1);
      start_run(1'b1);
      chk("nom START state", seq_state, 32'd1);
      chk("nom core_start", core_start, 32'd1);
      chk("nom prm_ready low", prm_ready, 32'd0);
      wait_cs("nom", 4);
      core_busy = 1'b1;
      while (cyc < 16) tick(1);
      core_done = 1'b1;
      tick(1);
      core_done = 1'b0;
      core_busy = 1'b0;
      chk("nom EMIT", seq_state, 32'd3);
      tick(1);
      chk("nom ol_start", ol_start, 32'd1);
      chk("nom WAIT_OL", seq_state, 32'd4);
      tick(1);
      chk("nom guard cycle", seq_state, 32'd4);
      ol_busy = 1'b1;
      tick(8);
      ol_busy = 1'b0;
      wait_idle("nom", 10);
      chk("nom ol_start count", ol_count, 32'd1);
      chk("nom core_start count", cs_count, 32'd1);
      chk("nom timeout", timeout, 32'd0);
      chk("nom prm_ready", prm_ready, 32'd1);

`ifdef EIG_SEQ_RETRY_EN
      // Single stall recovered by retry
      c0 = cyc;
      start_run(1'b1);
      exp_cs_q.push_back(c0 + 18);
      core_busy = 1'b1;
      wait_cs("retry first", 4);
      wait_cs("retry second", 30);
      chk("retry timeout", timeout, 32'd0);
      core_done = 1'b1;
      tick(1);
      core_done = 1'b0;
      core_busy = 1'b0;
      wait_idle("retry", 20);
      chk("retry done timeout", timeout, 32'd0);

      // Two stalls in one run
      c0 = cyc;
      start_run(1'b0);
      exp_cs_q.push_back(c0 + 18);
      core_busy = 1'b1;
      wait_cs("dbl first", 4);
      wait_cs("dbl second", 30);
      wait_fault(40);
      chk("dbl fault cycle", cyc, c0 + 35);
      chk("dbl timeout", timeout, 32'd1);
      core_busy = 1'b0;
      tick(1);
      chk("dbl IDLE", seq_state, 32'd0);
      chk("dbl run_count", run_count, int'(runs));
`else
      // Core stall
      c0 = cyc;
      start_run(1'b0);
      core_busy = 1'b1;
      wait_cs("stall", 4);
      wait_fault(40);
      chk("stall fault cycle", cyc, c0 + 18);
      chk("stall timeout", timeout, 32'd1);
      chk("stall prm_ready", prm_ready, 32'd0);
      tick(3);
      chk("stall held by busy", seq_state, 32'd5);
      core_busy = 1'b0;
      tick(1);
      chk("stall IDLE", seq_state, 32'd0);
      chk("stall prm_ready", prm_ready, 32'd1);
      chk("stall timeout kept", timeout, 32'd1);
      chk("stall run_count", run_count, int'(runs));
      chk("stall no extra start", cs_count, cs_seen);
`endif

      // core_done on the 16th WAIT_CORE cycle
      c0 = cyc;
      start_run(1'b1);
      chk("b16 timeout cleared", timeout, 32'd0);
      wait_cs("b16", 4);
      while (cyc < c0 + 17) tick(1);
      core_done = 1'b1;
      tick(1);
      core_done = 1'b0;
      chk("b16 EMIT", seq_state, 32'd3);
      chk("b16 no fault", timeout, 32'd0);
      wait_idle("b16", 20);

`ifndef EIG_SEQ_RETRY_EN
      // core_done on the 17th cycle is too late
      c0 = cyc;
      start_run(1'b0);
      core_busy = 1'b1;
      wait_cs("b17", 4);
      while (cyc < c0 + 18) tick(1);
      core_done = 1'b1;
      chk("b17 FAULT", seq_state, 32'd5);
      tick(1);
      core_done = 1'b0;
      chk("b17 done ignored", seq_state, 32'd5);
      chk("b17 timeout", timeout, 32'd1);
      core_busy = 1'b0;
      tick(1);
      chk("b17 IDLE", seq_state, 32'd0);
      chk("b17 run_count", run_count, int'(runs));
`endif

      // Overrun and ena freeze
      c0 = cyc;
      start_run(1'b1);
      core_busy = 1'b1;
      wait_cs("ovr", 4);
      tick(2);
      prm_valid = 1'b1;
      tick(1);
      prm_valid = 1'b0;
      chk("ovr overrun", overrun, 32'd1);
      chk("ovr state", seq_state, 32'd2);
      ena = 1'b0;
      tick(20);
      core_done = 1'b1;
      prm_valid = 1'b1;
      tick(1);
      core_done = 1'b0;
      prm_valid = 1'b0;
      tick(29);
      chk("ena0 state", seq_state, 32'd2);
      chk("ena0 timeout", timeout, 32'd0);
      chk("ena0 no start", cs_count, cs_seen);
      ena = 1'b1;
      tick(8);
      chk("ena1 state", seq_state, 32'd2);
      chk("ena1 timeout", timeout, 32'd0);
      core_done = 1'b1;
      tick(1);
      core_done = 1'b0;
      core_busy = 1'b0;
      wait_idle("ovr", 20);
      chk("ovr sticky", overrun, 32'd1);
      chk("ovr no extra start", cs_count, cs_seen);

      // run_count wrap
      quick_run("wrap first");
      chk("wrap overrun cleared", overrun, 32'd0);
      while (runs != 8'd0) quick_run("wrap");
      chk("wrap run_count zero", run_count, 32'd0);
      quick_run("post wrap");

      // Reset during WAIT_OL
      start_run(1'b0);
      wait_cs("rstol", 4);
      core_done = 1'b1;
      tick(1);
      core_done = 1'b0;
      tick(1);
      ol_busy = 1'b1;
      tick(2);
      prm_valid = 1'b1;
      tick(1);
      prm_valid = 1'b0;
      chk("rstol WAIT_OL", seq_state, 32'd4);
      chk("rstol overrun", overrun, 32'd1);
      ol_before = ol_count;
      #2 rst_n = 1'b0;
      #1;
      chk("rstol seq_state", seq_state, 32'd0);
      chk("rstol prm_ready", prm_ready, 32'd1);
      chk("rstol overrun", overrun, 32'd0);
      chk("rstol timeout", timeout, 32'd0);
      chk("rstol run_count", run_count, 32'd0);
      chk("rstol core_start", core_start, 32'd0);
      chk("rstol ol_start", ol_start, 32'd0);
      tick(2);
      rst_n = 1'b1;
      ol_busy = 1'b0;
      tick(20);
      chk("rstol no ol_start", ol_count, ol_before);
      chk("rstol no core_start", cs_count, cs_seen);
      chk("rstol run_count after", run_count, 32'd0);
      chk("rstol idle after", seq_state, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
